// File: rtl/fg_button_conditioner.sv
// Pushbutton conditioner: debounces a pre-synchronized level, emits press/release
// pulses, auto-repeat pulses while held and a long-press flag.
module fg_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 10000000,
  parameter int REPEAT_CYCLES   = 2500000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic sync_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o,
  output logic hold_o
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [DW-1:0]   r_deb_cnt;
  logic [DW-1:0]   w_deb_cnt_next;
  logic [HW-1:0]   r_hold_cnt;
  logic [HW-1:0]   w_hold_cnt_next;
  logic            r_level;
  logic            r_press;
  logic            r_release;
  logic            r_repeat;
  logic            w_differ;
  logic            w_toggle;
  logic            w_rise;
  logic            w_fall;
  logic            w_repeat_next;

  // The debounced level flips on the edge that sees the last of a run of differing samples.
  assign w_differ = (sync_i != r_level);
  assign w_toggle = w_differ && (r_deb_cnt == DEB_LAST);
  assign w_rise   = w_toggle && !r_level;
  assign w_fall   = w_toggle && r_level;

  always_comb begin
    w_deb_cnt_next = '0;
    if (w_differ && !w_toggle) begin
      w_deb_cnt_next = r_deb_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    w_repeat_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_next    = ST_HOLD;
          w_hold_cnt_next = '0;
        end
      end
      ST_HOLD: begin
        // A debounced release takes priority over a coincident count expiry.
        if (w_fall) begin
          w_state_next    = ST_IDLE;
          w_hold_cnt_next = '0;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_state_next    = ST_REPEAT;
          w_hold_cnt_next = '0;
          w_repeat_next   = 1'b1;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (w_fall) begin
          w_state_next    = ST_IDLE;
          w_hold_cnt_next = '0;
        end else if (r_hold_cnt == REP_LAST) begin
          w_hold_cnt_next = '0;
          w_repeat_next   = 1'b1;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_hold_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= ST_IDLE;
      r_deb_cnt  <= '0;
      r_hold_cnt <= '0;
      r_level    <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_repeat   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_deb_cnt  <= w_deb_cnt_next;
      r_hold_cnt <= w_hold_cnt_next;
      r_level    <= r_level ^ w_toggle;
      r_press    <= w_rise;
      r_release  <= w_fall;
      r_repeat   <= w_repeat_next;
    end
  end

  assign level_o   = r_level;
  assign press_o   = r_press;
  assign release_o = r_release;
  assign repeat_o  = r_repeat;
  assign hold_o    = (r_state == ST_REPEAT);

endmodule

// File: tb/tb_fg_button_conditioner.sv
// Bench for fg_button_conditioner: vector table, directed corner sequences and
// random bounce stimulus against a cycle-count reference model.
module tb_fg_button_conditioner;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic clk_i;
  logic rstn_i;
  logic sync_i;
  logic level_o;
  logic press_o;
  logic release_o;
  logic repeat_o;
  logic hold_o;

  fg_button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .sync_i(sync_i),
    .level_o(level_o),
    .press_o(press_o),
    .release_o(release_o),
    .repeat_o(repeat_o),
    .hold_o(hold_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks;
  int failures;
  int cyc;

  // Reference model: run length of differing samples, and cycles elapsed since press.
  bit m_level;
  bit m_press;
  bit m_release;
  bit m_repeat;
  bit m_hold;
  int m_run;
  int m_t;

  function automatic logic [4:0] outs();
    return {level_o, press_o, release_o, repeat_o, hold_o};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_press = 0; m_release = 0; m_repeat = 0; m_hold = 0;
    m_run = 0; m_t = 0;
  endtask

  task automatic model_step(input bit s);
    m_press = 0;
    m_release = 0;
    if (s != m_level) m_run++;
    else m_run = 0;
    if (m_run == D) begin
      m_level = !m_level;
      m_run = 0;
      if (m_level) m_press = 1;
      else m_release = 1;
    end
    if (m_press) m_t = 0;
    else if (m_level) m_t++;
    m_hold = m_level && (m_t >= H);
    m_repeat = m_hold && (((m_t - H) % R) == 0);
  endtask

  // Apply one sample, clock it in, then compare every output against the model.
  task automatic tick(input bit s);
    sync_i = s;
    @(posedge clk_i);
    #1;
    cyc++;
    model_step(s);
    check("model", 32'(outs()), 32'({m_level, m_press, m_release, m_repeat, m_hold}));
  endtask

  typedef struct {
    logic       s;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[14];
  int   rep_q[$];
  int   exp_rep[6];
  int   p_cyc;
  int   n_rel;
  int   n_seen;
  bit   hold_seen;
  bit   rep_seen;
  bit   press_seen;
  int   val;
  int   len;

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    model_reset();
    rstn_i = 1'b0;
    sync_i = 1'b0;

    // Glitch rejection (rows 0..8) then clean press (rows 9..13); fields are
    // {level, press, release, repeat, hold}.
    vecs[0]  = '{1'b1, 5'b00000};
    vecs[1]  = '{1'b1, 5'b00000};
    vecs[2]  = '{1'b1, 5'b00000};
    vecs[3]  = '{1'b0, 5'b00000};
    vecs[4]  = '{1'b1, 5'b00000};
    vecs[5]  = '{1'b1, 5'b00000};
    vecs[6]  = '{1'b1, 5'b00000};
    vecs[7]  = '{1'b0, 5'b00000};
    vecs[8]  = '{1'b0, 5'b00000};
    vecs[9]  = '{1'b1, 5'b00000};
    vecs[10] = '{1'b1, 5'b00000};
    vecs[11] = '{1'b1, 5'b00000};
    vecs[12] = '{1'b1, 5'b11000};
    vecs[13] = '{1'b1, 5'b10000};
    exp_rep = '{10, 13, 16, 19, 22, 25};

    #12;
    check("reset_outputs", 32'(outs()), 32'd0);
    rstn_i = 1'b1;

    p_cyc = 0;
    for (int i = 0; i < 14; i++) begin
      tick(vecs[i].s);
      check($sformatf("vec[%0d]", i), 32'(outs()), 32'(vecs[i].exp));
      if (i == 12) p_cyc = cyc;
    end

    // Auto-repeat timing relative to the press cycle.
    rep_q.delete();
    while (cyc < p_cyc + 25) begin
      tick(1'b1);
      if (repeat_o) rep_q.push_back(cyc - p_cyc);
    end
    check("repeat_count", 32'(rep_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < rep_q.size()) check($sformatf("repeat_at[%0d]", i), 32'(rep_q[i]), 32'(exp_rep[i]));
    end
    check("hold_in_repeat", 32'(hold_o), 32'd1);

    // Release bounce: only the final run of four lows counts.
    n_rel = 0;
    for (int i = 0; i < 7; i++) begin
      tick((i == 2) ? 1'b1 : 1'b0);
      if (release_o) n_rel++;
    end
    check("bounce_release_last", 32'(release_o), 32'd1);
    check("bounce_release_count", 32'(n_rel), 32'd1);
    check("bounce_level", 32'(level_o), 32'd0);

    // Release landing exactly on the hold expiry.
    for (int i = 0; i < 3; i++) tick(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1);
    check("p4_press", 32'(press_o), 32'd1);
    p_cyc = cyc;
    hold_seen = 0;
    rep_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1);
      hold_seen |= hold_o; rep_seen |= repeat_o;
    end
    for (int i = 0; i < 4; i++) begin
      tick(1'b0);
      hold_seen |= hold_o; rep_seen |= repeat_o;
    end
    check("p4_cycle", 32'(cyc - p_cyc), 32'd10);
    check("p4_release", 32'(release_o), 32'd1);
    check("p4_repeat", 32'(repeat_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0);
      hold_seen |= hold_o; rep_seen |= repeat_o;
    end
    check("p4_hold_never", 32'(hold_seen), 32'd0);
    check("p4_repeat_never", 32'(rep_seen), 32'd0);

    // Asynchronous reset in the middle of REPEAT.
    for (int i = 0; i < 4; i++) tick(1'b1);
    for (int i = 0; i < 12; i++) tick(1'b1);
    check("p6_hold_before", 32'(hold_o), 32'd1);
    #3;
    rstn_i = 1'b0;
    #1;
    check("p6_async_reset", 32'(outs()), 32'd0);
    #2;
    rstn_i = 1'b1;
    model_reset();
    n_seen = 0;
    press_seen = 0;
    while (!press_seen && n_seen < 20) begin
      tick(1'b1);
      n_seen++;
      press_seen = press_o;
    end
    check("p6_press_after", 32'(n_seen), 32'd4);
    n_seen = 0;
    rep_seen = 0;
    while (!rep_seen && n_seen < 30) begin
      tick(1'b1);
      n_seen++;
      rep_seen = repeat_o;
    end
    check("p6_first_repeat", 32'(n_seen), 32'd10);

    // Random bouncy runs, some long enough to reach auto-repeat.
    for (int k = 0; k < 600; k++) begin
      val = $urandom_range(0, 1);
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 6);
      for (int j = 0; j < len; j++) tick(val[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
